// File: rtl/mem_access_unit.sv
// mem_access_unit: core-side load/store initiator for a word-organised data memory.
// Accepts one RV32 load/store per handshake, issues one or two word-aligned beats,
// waits for mem_ready (with optional timeout) and returns extended load data.
// Compile-time option: define MISALIGNED_SPLIT_EN to split word-crossing accesses
// into two beats; otherwise misaligned H/W accesses are rejected with resp_err.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t state, state_d;

  // registered request context
  logic              r_store, r_store_d;
  logic [2:0]        r_funct3, r_funct3_d;
  logic [1:0]        r_off, r_off_d;
  logic [3:0]        r_be_hi, r_be_hi_d;
  logic [31:0]       r_wd_hi, r_wd_hi_d;
  logic [31:0]       buf_lo, buf_lo_d;
  logic [CNT_W-1:0]  tcnt, tcnt_d;

  // next values of the registered outputs
  logic              req_ready_d, resp_valid_d, resp_err_d, mem_re_d, mem_we_d;
  logic [31:0]       resp_rdata_d, mem_wdata_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [3:0]        mem_be_d;

  // request decode: lane placement and legality
  logic [1:0]  req_off;
  logic [3:0]  req_mask;
  logic [7:0]  req_be8;
  logic [63:0] req_wd64;
  logic        f3_legal, misaligned, req_bad;

  // beat-side helpers
  logic        tmo_hit;
  logic [63:0] beat64;

  // shift the assembled buffer down to the byte offset and extend to 32 bits
  function automatic logic [31:0] extract(input logic [63:0] b, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(b >> {off, 3'b000});
    case (f3)
      3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extract = {24'd0, sh[7:0]};
      3'b101:  extract = {16'd0, sh[15:0]};
      default: extract = sh;
    endcase
  endfunction

  // decode the incoming request into lane enables, positioned data and an error flag
  always_comb begin
    req_off = req_addr[1:0];
    case (req_funct3[1:0])
      2'b00:   req_mask = 4'h1;
      2'b01:   req_mask = 4'h3;
      default: req_mask = 4'hF;
    endcase
    req_be8  = {4'h0, req_mask} << req_off;
    req_wd64 = {32'd0, req_wdata} << {req_off, 3'b000};
    if (req_store) f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                              (req_funct3 == 3'b010);
    else           f3_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                              (req_funct3 != 3'b111);
`ifdef MISALIGNED_SPLIT_EN
    misaligned = 1'b0;
`else
    misaligned = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
`endif
    req_bad = !f3_legal || misaligned;
  end

  // timeout detection and load-buffer assembly for the current beat
  always_comb begin
    tmo_hit = TMO_EN && !mem_ready && (tcnt == TMO_LAST);
    beat64  = (state == BEAT1) ? {mem_rdata, buf_lo} : {32'd0, mem_rdata};
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (req_valid) state_d = req_bad ? RESP : BEAT0;
      BEAT0: begin
        if (mem_ready)    state_d = (r_be_hi != 4'h0) ? BEAT1 : RESP;
        else if (tmo_hit) state_d = RESP;
      end
      BEAT1: if (mem_ready || tmo_hit) state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'd0;
    mem_re_d     = mem_re;
    mem_we_d     = mem_we;
    mem_addr_d   = mem_addr;
    mem_be_d     = mem_be;
    mem_wdata_d  = mem_wdata;
    r_store_d    = r_store;
    r_funct3_d   = r_funct3;
    r_off_d      = r_off;
    r_be_hi_d    = r_be_hi;
    r_wd_hi_d    = r_wd_hi;
    buf_lo_d     = buf_lo;
    tcnt_d       = tcnt;
    case (state)
      IDLE: begin
        if (req_valid) begin
          r_store_d  = req_store;
          r_funct3_d = req_funct3;
          r_off_d    = req_off;
          r_be_hi_d  = req_be8[7:4];
          r_wd_hi_d  = req_wd64[63:32];
          tcnt_d     = '0;
          if (req_bad) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            mem_re_d    = !req_store;
            mem_we_d    = req_store;
            mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = req_be8[3:0];
            mem_wdata_d = req_wd64[31:0];
          end
        end
      end
      BEAT0, BEAT1: begin
        if (mem_ready) begin
          buf_lo_d = mem_rdata;
          if ((state == BEAT0) && (r_be_hi != 4'h0)) begin
            mem_addr_d  = mem_addr + ADDR_W'(4);
            mem_be_d    = r_be_hi;
            mem_wdata_d = r_wd_hi;
            tcnt_d      = '0;
          end else begin
            mem_re_d     = 1'b0;
            mem_we_d     = 1'b0;
            resp_valid_d = 1'b1;
            resp_rdata_d = r_store ? 32'd0 : extract(beat64, r_off, r_funct3);
          end
        end else if (tmo_hit) begin
          mem_re_d     = 1'b0;
          mem_we_d     = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else if (TMO_EN) begin
          tcnt_d = tcnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'h0;
      mem_wdata  <= 32'd0;
      r_store    <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_be_hi    <= 4'h0;
      r_wd_hi    <= 32'd0;
      buf_lo     <= 32'd0;
      tcnt       <= '0;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_re     <= mem_re_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_be     <= mem_be_d;
      mem_wdata  <= mem_wdata_d;
      r_store    <= r_store_d;
      r_funct3   <= r_funct3_d;
      r_off      <= r_off_d;
      r_be_hi    <= r_be_hi_d;
      r_wd_hi    <= r_wd_hi_d;
      buf_lo     <= buf_lo_d;
      tcnt       <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: memory model with programmable ready delay,
// response and beat scoreboards, latency and strobe-stability checks.
// Covers both builds of MISALIGNED_SPLIT_EN.
module tb_mem_access_unit;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_store = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] rdata; logic err; int t_acc; int lat;} resp_t;
  typedef struct {logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;} beat_t;

  resp_t exp_q[$];
  beat_t beat_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wait_cnt = 0;
  int ready_delay = 0;
  bit stuck = 1'b0;
  int strobes = 0;

  logic [31:0] mem [0:63];
  bit          pend = 1'b0;
  logic [35:0] pend_ab;
  logic [31:0] pend_wd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
  endfunction

  // memory model: ready after ready_delay wait cycles per beat, never when stuck
  assign mem_ready = !stuck && (wait_cnt >= ready_delay);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((mem_re || mem_we) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
      mem[4] <= 32'h80FF_1234;
      mem[5] <= 32'h0000_0055;
    end else if (mem_we && mem_ready) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  // response scoreboard
  always @(negedge clk) begin : resp_mon
    resp_t e;
    if (!reset && resp_valid) begin
      if (exp_q.size() == 0) check("unexp_resp", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", resp_err, e.err);
        if (e.lat >= 0) check("resp_latency", cyc - e.t_acc, e.lat);
      end
    end
  end

  // beat scoreboard, strobe counting and in-beat stability
  always @(negedge clk) begin : beat_mon
    beat_t b;
    if (!reset && (mem_re || mem_we)) begin
      strobes <= strobes + 1;
      if (pend) begin
        check("beat_stable_addr_be", {mem_addr, mem_be}, pend_ab);
        check("beat_stable_wdata", mem_wdata, pend_wd);
      end
      if (mem_ready) begin
        if (beat_q.size() == 0) check("unexp_beat", 1, 0);
        else begin
          b = beat_q.pop_front();
          check("beat_addr", mem_addr, b.addr);
          check("beat_be", mem_be, b.be);
          check("beat_we", {mem_we, mem_re}, {b.we, !b.we});
          if (b.we) check("beat_wdata", mem_wdata & lane_mask(b.be), b.wdata & lane_mask(b.be));
        end
      end
    end
    pend    <= !reset && (mem_re || mem_we) && !mem_ready;
    pend_ab <= {mem_addr, mem_be};
    pend_wd <= mem_wdata;
  end

  task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input bit we,
                           input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    beat_q.push_back(b);
  endtask

  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input bit ee,
                       input int lat, input bit want_resp);
    int w = 0;
    resp_t e;
    while (!req_ready && w < 60) begin @(negedge clk); w++; end
    if (w >= 60) check("req_ready_wait", 0, 1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (want_resp) begin
      e.rdata = er; e.err = ee; e.t_acc = cyc; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    do begin @(negedge clk); w++; end
    while ((exp_q.size() != 0 || beat_q.size() != 0 || !req_ready) && w < 100);
    check(tag, exp_q.size() + beat_q.size(), 0);
  endtask

  initial begin
    int s0;
    int w;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", {resp_valid, resp_err}, 0);
    check("rst_strobes", {mem_re, mem_we}, 0);
    check("rst_mem_be_addr", {mem_be, mem_addr}, 0);
    check("rst_data", {mem_wdata, resp_rdata}, 0);

    // byte and halfword loads from a preloaded word
    push_beat(32'h10, 4'b0010, 1'b0, 0);
    issue(1'b0, 3'b000, 32'h11, 0, 32'h0000_0012, 1'b0, 2, 1'b1);
    drain("lb_drain");
    push_beat(32'h10, 4'b1100, 1'b0, 0);
    issue(1'b0, 3'b101, 32'h12, 0, 32'h0000_80FF, 1'b0, 2, 1'b1);
    drain("lhu_drain");
    push_beat(32'h10, 4'b1100, 1'b0, 0);
    issue(1'b0, 3'b001, 32'h12, 0, 32'hFFFF_80FF, 1'b0, 2, 1'b1);
    drain("lh_drain");

    // word store held through three not-ready cycles, then read back
    ready_delay = 3;
    s0 = strobes;
    push_beat(32'h20, 4'b1111, 1'b1, 32'hDEAD_BEEF);
    issue(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 1'b0, 5, 1'b1);
    drain("sw_drain");
    check("sw_strobe_cycles", strobes - s0, 4);
    ready_delay = 0;
    push_beat(32'h20, 4'b1111, 1'b0, 0);
    issue(1'b0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 1'b0, 2, 1'b1);
    drain("lw_drain");

    // byte store lane placement and loads of the stored byte
    push_beat(32'h30, 4'b0010, 1'b1, 32'h0000_A500);
    issue(1'b1, 3'b000, 32'h31, 32'h1234_56A5, 0, 1'b0, 2, 1'b1);
    push_beat(32'h30, 4'b1111, 1'b0, 0);
    issue(1'b0, 3'b010, 32'h30, 0, 32'h0000_A500, 1'b0, 2, 1'b1);
    push_beat(32'h30, 4'b0010, 1'b0, 0);
    issue(1'b0, 3'b000, 32'h31, 0, 32'hFFFF_FFA5, 1'b0, 2, 1'b1);
    push_beat(32'h30, 4'b0010, 1'b0, 0);
    issue(1'b0, 3'b100, 32'h31, 0, 32'h0000_00A5, 1'b0, 2, 1'b1);
    drain("sb_drain");

    // misaligned accesses
    s0 = strobes;
`ifdef MISALIGNED_SPLIT_EN
    push_beat(32'h20, 4'b1000, 1'b1, 32'hDD00_0000);
    push_beat(32'h24, 4'b0111, 1'b1, 32'h00AA_BBCC);
    issue(1'b1, 3'b010, 32'h23, 32'hAABB_CCDD, 0, 1'b0, 3, 1'b1);
    drain("split_sw_drain");
    push_beat(32'h20, 4'b1000, 1'b0, 0);
    push_beat(32'h24, 4'b0111, 1'b0, 0);
    issue(1'b0, 3'b010, 32'h23, 0, 32'hAABB_CCDD, 1'b0, 3, 1'b1);
    push_beat(32'h10, 4'b1000, 1'b0, 0);
    push_beat(32'h14, 4'b0001, 1'b0, 0);
    issue(1'b0, 3'b001, 32'h13, 0, 32'h0000_5580, 1'b0, 3, 1'b1);
    push_beat(32'h10, 4'b0110, 1'b0, 0);
    issue(1'b0, 3'b001, 32'h11, 0, 32'hFFFF_FF12, 1'b0, 2, 1'b1);
    drain("split_ld_drain");
    check("split_strobe_cycles", strobes - s0, 7);
`else
    issue(1'b1, 3'b010, 32'h23, 32'hAABB_CCDD, 0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b010, 32'h23, 0, 0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b001, 32'h11, 0, 0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b001, 32'h13, 32'h1234_5678, 0, 1'b1, 1, 1'b1);
    drain("misaligned_drain");
    check("misaligned_no_strobe", strobes - s0, 0);
`endif

    // timeout on a stuck memory, then illegal funct3 codes
    stuck = 1'b1;
    s0 = strobes;
    issue(1'b0, 3'b010, 32'h40, 0, 0, 1'b1, 17, 1'b1);
    drain("timeout_drain");
    check("timeout_wait_cycles", strobes - s0, 16);
    stuck = 1'b0;
    s0 = strobes;
    issue(1'b0, 3'b011, 32'h10, 0, 0, 1'b1, 1, 1'b1);
    issue(1'b1, 3'b100, 32'h10, 32'h55, 0, 1'b1, 1, 1'b1);
    issue(1'b0, 3'b110, 32'h10, 0, 0, 1'b1, 1, 1'b1);
    drain("illegal_drain");
    check("illegal_no_strobe", strobes - s0, 0);

    // reset in the middle of a beat drops the transaction
    stuck = 1'b1;
    issue(1'b0, 3'b010, 32'h40, 0, 0, 1'b0, -1, 1'b0);
    w = 0;
    while (!mem_re && w < 10) begin @(negedge clk); w++; end
    check("mid_reset_in_beat", mem_re, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_reset_strobes", {mem_re, mem_we}, 0);
    check("mid_reset_ready", req_ready, 1);
    check("mid_reset_no_resp", resp_valid, 0);
    stuck = 1'b0;
    repeat (3) @(negedge clk);
    push_beat(32'h10, 4'b1111, 1'b0, 0);
    issue(1'b0, 3'b010, 32'h10, 0, 32'h80FF_1234, 1'b0, 2, 1'b1);
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
